uart_rx_packet_ctrl: RTL
========================

// Module: uart_rx_packet_ctrl
// PURPOSE
//  Sequences the UART byte receiver: acknowledges each received byte, hunts for a sync byte,
//  assembles a fixed-length payload plus XOR checksum, and presents the packet to the command
//  decoder with a valid/ready handshake. Sits between the UART receiver and the command logic.
//  Aborts on line errors and inter-byte timeouts, and counts dropped packets.
// PARAMETERS
//  SYNC_BYTE  8'hAA  header value that starts a packet
//  PKT_LEN    4      payload bytes per packet (1..8)
//  TIMEOUT    20000  max clk cycles between bytes inside a packet (>=2)
// PORTS
//  clk        in   1            system clock, posedge
//  rst_n      in   1            async active-low reset
//  rx_data    in   8            byte from receiver, valid while rx_sent=1
//  rx_sent    in   1            receiver has a good byte pending (level, held until ack seen)
//  rx_error   in   4            receiver frame status (0 = ok; 1 = parity; 2 = stop)
//  rx_ack     out  1            one-cycle pulse: byte consumed (drives receiver 'recieved')
//  pkt_data   out  8*PKT_LEN    payload; byte 0 (first received) in bits [7:0]
//  pkt_valid  out  1            packet available; held until pkt_ready
//  pkt_ready  in   1            consumer accepts packet when pkt_valid & pkt_ready
//  crc_err    out  1            one-cycle pulse: checksum mismatch, packet dropped
//  timeout_err out 1            one-cycle pulse: inter-byte timeout, packet dropped
//  frame_err  out  1            one-cycle pulse: rx_error!=0 mid-packet, packet dropped
//  drop_cnt   out  8            dropped packets, saturates at 8'hFF
// BEHAVIOUR
//  Reset: all outputs 0, pkt_data 0, state HUNT, byte index 0, timer 0, checksum 0.
//  Byte intake: when rx_sent=1, state != HOLD and no ack is outstanding -> capture rx_data,
//   pulse rx_ack for exactly 1 cycle, then set ack_pend. Ignore rx_sent until it reads 0
//   (receiver clears it on its own edge), then clear ack_pend. One capture per byte, never two.
//  States:
//   HUNT: captured byte == SYNC_BYTE -> PAYLOAD (index=0, csum=0, timer=0); else stay (no count).
//   PAYLOAD: store byte at index, csum ^= byte; index==PKT_LEN-1 -> CHECK, else index+1.
//   CHECK: captured byte == csum -> HOLD, pkt_valid=1 next cycle; else crc_err pulse, drop, HUNT.
//   HOLD: pkt_valid=1, pkt_data stable; rx bytes not acked (remain pending at receiver).
//    pkt_ready=1 -> pkt_valid=0 next cycle, -> HUNT. Pending byte is consumed from HUNT.
//  Timer: in PAYLOAD/CHECK, counts cycles since the last ack; reset to 0 on each ack.
//   timer == TIMEOUT-1 with no byte -> timeout_err pulse, drop, HUNT.
//  rx_error != 0 while in PAYLOAD/CHECK -> frame_err pulse, drop, HUNT (priority over timeout).
//   Ignored in HUNT/HOLD.
//  Same-cycle byte capture and timeout expiry: the byte wins and the timer clears.
//  Drop: drop_cnt+1 unless 8'hFF; pkt_valid is never asserted for a dropped packet.
//  Latency: pkt_valid rises 1 cycle after the cycle the checksum byte is captured.
//  A sync value inside the payload is treated as data (no resync mid-packet).
//  Async reset mid-packet: return to reset values immediately; a partial packet is discarded
//   without incrementing drop_cnt.
// TESTING
//  Bytes AA,01,02,03,04,04 -> one rx_ack per byte; pkt_valid, pkt_data=32'h04030201.
//  Bytes AA,01,02,03,04,00 -> crc_err pulse; drop_cnt=1; pkt_valid stays 0.
//  Bytes AA,11, then silence TIMEOUT cycles -> timeout_err pulse; next AA starts a new packet.
//  Good packet with pkt_ready=0, then byte 55 sent -> no rx_ack while pkt_valid=1;
//   pkt_ready=1 -> ack of 55 after return to HUNT.
//  Bytes AA,01, then rx_error=1 -> frame_err pulse, HUNT; rst_n low mid-packet -> all outputs 0.
//  rx_sent held high 10 cycles for one byte -> exactly one rx_ack pulse.

Source files
------------

// File: rtl/uart_rx_packet_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_packet_ctrl
// Description : Acknowledges UART bytes, hunts for a sync byte, assembles a
//               fixed-length payload with XOR checksum and hands it off via
//               valid/ready. Aborts on line errors or inter-byte timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hAA,
    parameter int         PKT_LEN   = 4,
    parameter int         TIMEOUT   = 20000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_sent_i,
    input  logic [3:0]             rx_error_i,
    output logic                   rx_ack_o,
    output logic [8*PKT_LEN-1:0]   pkt_data_o,
    output logic                   pkt_valid_o,
    input  logic                   pkt_ready_i,
    output logic                   crc_err_o,
    output logic                   timeout_err_o,
    output logic                   frame_err_o,
    output logic [7:0]             drop_cnt_o
);

    localparam int c_idx_w = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int c_tmr_w = $clog2(TIMEOUT);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PKT_LEN - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [c_idx_w-1:0]      idx_q, idx_d;
    logic [c_tmr_w-1:0]      timer_q, timer_d;
    logic [7:0]              csum_q, csum_d;
    logic [8*PKT_LEN-1:0]    pkt_q, pkt_d;
    logic                    valid_q, valid_d;
    logic                    ack_q, ack_d;
    logic                    ack_pend_q, ack_pend_d;
    logic                    crc_q, crc_d;
    logic                    tout_q, tout_d;
    logic                    frame_q, frame_d;
    logic [7:0]              drop_q, drop_d;

    logic                    w_in_pkt;
    logic                    w_frame;
    logic                    w_take;
    logic                    w_drop;

    // A line error mid-packet pre-empts the byte; the byte stays pending and is
    // consumed later from HUNT.
    assign w_in_pkt = (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign w_frame  = w_in_pkt && (rx_error_i != 4'd0);
    assign w_take   = rx_sent_i && (state_q != S_HOLD) && !ack_pend_q && !w_frame;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        csum_d     = csum_q;
        pkt_d      = pkt_q;
        valid_d    = valid_q;
        crc_d      = 1'b0;
        tout_d     = 1'b0;
        frame_d    = 1'b0;
        w_drop     = 1'b0;
        ack_d      = w_take;
        ack_pend_d = ack_pend_q;

        if (w_take) begin
            ack_pend_d = 1'b1;
        end else if (!rx_sent_i) begin
            ack_pend_d = 1'b0;
        end

        case (state_q)
            S_HUNT: begin
                if (w_take && (rx_data_i == SYNC_BYTE)) begin
                    state_d = S_PAYLOAD;
                    idx_d   = '0;
                    csum_d  = 8'd0;
                    timer_d = '0;
                end
            end
            S_PAYLOAD, S_CHECK: begin
                if (w_frame) begin
                    frame_d = 1'b1;
                    w_drop  = 1'b1;
                    state_d = S_HUNT;
                    timer_d = '0;
                end else if (w_take) begin
                    timer_d = '0;
                    if (state_q == S_PAYLOAD) begin
                        for (int i = 0; i < PKT_LEN; i++) begin
                            if (idx_q == c_idx_w'(i)) begin
                                pkt_d[i*8 +: 8] = rx_data_i;
                            end
                        end
                        csum_d = csum_q ^ rx_data_i;
                        if (idx_q == c_last_idx) begin
                            state_d = S_CHECK;
                        end else begin
                            idx_d = idx_q + c_idx_w'(1);
                        end
                    end else if (rx_data_i == csum_q) begin
                        state_d = S_HOLD;
                        valid_d = 1'b1;
                    end else begin
                        crc_d   = 1'b1;
                        w_drop  = 1'b1;
                        state_d = S_HUNT;
                    end
                end else if (timer_q == c_tmr_last) begin
                    tout_d  = 1'b1;
                    w_drop  = 1'b1;
                    state_d = S_HUNT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + c_tmr_w'(1);
                end
            end
            S_HOLD: begin
                if (pkt_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_HUNT;
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        drop_d = (w_drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HUNT;
            idx_q      <= '0;
            timer_q    <= '0;
            csum_q     <= 8'd0;
            pkt_q      <= '0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            ack_pend_q <= 1'b0;
            crc_q      <= 1'b0;
            tout_q     <= 1'b0;
            frame_q    <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            csum_q     <= csum_d;
            pkt_q      <= pkt_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            ack_pend_q <= ack_pend_d;
            crc_q      <= crc_d;
            tout_q     <= tout_d;
            frame_q    <= frame_d;
            drop_q     <= drop_d;
        end
    end

    assign rx_ack_o      = ack_q;
    assign pkt_data_o    = pkt_q;
    assign pkt_valid_o   = valid_q;
    assign crc_err_o     = crc_q;
    assign timeout_err_o = tout_q;
    assign frame_err_o   = frame_q;
    assign drop_cnt_o    = drop_q;

endmodule
`default_nettype wire
